// File: rtl/mips_run_pkg.sv
// Shared definitions for the MIPS32 load/run/dump controller: FSM encodings,
// width helper, default watchdog limit and the loader checksum step.
package mips_run_pkg;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LOAD = 3'd1;
  localparam logic [2:0] ST_RUN  = 3'd2;
  localparam logic [2:0] ST_DUMP = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  localparam int unsigned DEF_TIMEOUT_CYC = 1000;

  // clog2 with a floor of one bit so degenerate depths still give legal vectors
  function automatic int unsigned w_of(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // rotate-left-by-one then XOR, evaluated on the low w bits (w <= 64)
  function automatic logic [63:0] cksum_step(input logic [63:0] acc,
                                             input logic [63:0] word,
                                             input int unsigned w);
    logic [63:0] mask;
    mask = {64{1'b1}} >> (64 - w);
    return (((acc << 1) | (acc >> (w - 1))) & mask) ^ (word & mask);
  endfunction

endpackage

// File: rtl/mips_run_dump_stream.sv
// DUMP-phase register readout: one read per index, holding register for the
// registered-read data, and a valid/ready output that overlaps reads with handshakes.
module mips_run_dump_stream import mips_run_pkg::*; #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned NUM_REGS   = 32,
  parameter int unsigned DUMP_FIRST = 0,
  parameter int unsigned DUMP_COUNT = 6,
  localparam int unsigned RW        = w_of(NUM_REGS),
  localparam int unsigned LW        = RW + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  output logic              fin_o,
  output logic [RW-1:0]     reg_raddr_o,
  input  logic [DATA_W-1:0] reg_rdata_i,
  output logic              dump_valid_o,
  output logic [RW-1:0]     dump_idx_o,
  output logic [DATA_W-1:0] dump_data_o,
  input  logic              dump_ready_i
);

  localparam logic [LW-1:0] CNT_INIT = LW'(DUMP_COUNT);
  localparam logic [RW-1:0] FIRST    = RW'(DUMP_FIRST);

  logic              active_q, vld_q, fresh_q;
  logic [RW-1:0]     ptr_q, idx_q;
  logic [LW-1:0]     left_q;
  logic [DATA_W-1:0] hold_q;
  logic              issue, pop;

  assign issue = active_q && (left_q != '0) && (!vld_q || dump_ready_i);
  assign pop   = vld_q && dump_ready_i;
  assign fin_o = active_q && (left_q == '0) && (!vld_q || dump_ready_i);

  // fresh_q marks the first cycle after a read, when reg_rdata is live
  assign reg_raddr_o  = issue ? ptr_q : '0;
  assign dump_valid_o = vld_q;
  assign dump_idx_o   = idx_q;
  assign dump_data_o  = !vld_q ? '0 : (fresh_q ? reg_rdata_i : hold_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      active_q <= 1'b0;
      vld_q    <= 1'b0;
      fresh_q  <= 1'b0;
      ptr_q    <= '0;
      idx_q    <= '0;
      left_q   <= '0;
      hold_q   <= '0;
    end else begin
      fresh_q <= issue;
      if (fresh_q) hold_q <= reg_rdata_i;
      if (start_i) begin
        active_q <= 1'b1;
        ptr_q    <= FIRST;
        left_q   <= CNT_INIT;
      end else if (fin_o) begin
        active_q <= 1'b0;
      end
      if (issue) begin
        ptr_q  <= ptr_q + 1'b1;
        left_q <= left_q - 1'b1;
        idx_q  <= ptr_q;
        vld_q  <= 1'b1;
      end else if (pop) begin
        vld_q  <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/mips_run_ctrl.sv
// Program-load / run / register-dump controller for the MIPS32 core.
// Optional MIPS_RUN_CKSUM_EN adds prog_cksum, a rotate-xor digest of loaded words.
module mips_run_ctrl import mips_run_pkg::*; #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned IMEM_DEPTH  = 1024,
  parameter int unsigned NUM_REGS    = 32,
  parameter int unsigned DUMP_FIRST  = 0,
  parameter int unsigned DUMP_COUNT  = 6,
  parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  localparam int unsigned AW         = w_of(IMEM_DEPTH),
  localparam int unsigned RW         = w_of(NUM_REGS),
  localparam int unsigned CW         = w_of(TIMEOUT_CYC + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              prog_valid,
  input  logic [DATA_W-1:0] prog_data,
  input  logic              prog_last,
  output logic              prog_ready,
  output logic              cpu_rst,
  output logic              imem_we,
  output logic [AW-1:0]     imem_addr,
  output logic [DATA_W-1:0] imem_wdata,
  input  logic              cpu_halted,
  output logic [RW-1:0]     reg_raddr,
  input  logic [DATA_W-1:0] reg_rdata,
  output logic              dump_valid,
  output logic [RW-1:0]     dump_idx,
  output logic [DATA_W-1:0] dump_data,
  input  logic              dump_ready,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic              overflow,
  output logic [CW-1:0]     cycle_count
`ifdef MIPS_RUN_CKSUM_EN
  ,
  output logic [DATA_W-1:0] prog_cksum
`endif
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(IMEM_DEPTH - 1);
  localparam logic [CW-1:0] TO_LIM    = CW'(TIMEOUT_CYC);
  localparam bit            HAS_DUMP  = (DUMP_COUNT != 0);

  logic [2:0]    state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic          timeout_q, timeout_d, overflow_q, overflow_d;
  logic          accept, go_end, dump_start, dump_fin;

  assign prog_ready  = (state_q == ST_LOAD);
  assign accept      = prog_valid && prog_ready;
  assign imem_we     = accept;
  assign imem_addr   = addr_q;
  assign imem_wdata  = accept ? prog_data : '0;
  assign cpu_rst     = !((state_q == ST_RUN) || (state_q == ST_DUMP));
  assign busy        = (state_q != ST_IDLE);
  assign done        = (state_q == ST_DONE);
  assign timeout     = timeout_q;
  assign overflow    = overflow_q;
  assign cycle_count = cyc_q;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    cyc_d      = cyc_q;
    timeout_d  = timeout_q;
    overflow_d = overflow_q;
    go_end     = 1'b0;
    dump_start = 1'b0;
    case (state_q)
      ST_IDLE: if (start) begin
        timeout_d  = 1'b0;
        overflow_d = 1'b0;
        cyc_d      = '0;
        addr_d     = '0;
        state_d    = ST_LOAD;
      end
      ST_LOAD: if (accept) begin
        // the last address never wraps: a full memory without prog_last ends the load
        if (addr_q != LAST_ADDR) addr_d = addr_q + 1'b1;
        if (prog_last) begin
          state_d = ST_RUN;
        end else if (addr_q == LAST_ADDR) begin
          overflow_d = 1'b1;
          state_d    = ST_RUN;
        end
      end
      ST_RUN: begin
        if (cpu_halted) begin
          go_end = 1'b1;
        end else begin
          cyc_d = cyc_q + 1'b1;
          if (cyc_d == TO_LIM) begin
            timeout_d = 1'b1;
            go_end    = 1'b1;
          end
        end
        if (go_end) begin
          state_d    = HAS_DUMP ? ST_DUMP : ST_DONE;
          dump_start = HAS_DUMP;
        end
      end
      ST_DUMP: if (dump_fin) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      cyc_q      <= '0;
      timeout_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      cyc_q      <= cyc_d;
      timeout_q  <= timeout_d;
      overflow_q <= overflow_d;
    end
  end

`ifdef MIPS_RUN_CKSUM_EN
  logic [DATA_W-1:0] cksum_q, cksum_d;

  always_comb begin
    cksum_d = cksum_q;
    if (state_q == ST_IDLE && start) cksum_d = '0;
    else if (accept) cksum_d = DATA_W'(cksum_step(64'(cksum_q), 64'(prog_data), DATA_W));
  end

  always_ff @(posedge clk) begin
    if (rst) cksum_q <= '0;
    else     cksum_q <= cksum_d;
  end

  assign prog_cksum = cksum_q;
`endif

  mips_run_dump_stream #(
    .DATA_W     (DATA_W),
    .NUM_REGS   (NUM_REGS),
    .DUMP_FIRST (DUMP_FIRST),
    .DUMP_COUNT (DUMP_COUNT)
  ) u_dump (
    .clk          (clk),
    .rst          (rst),
    .start_i      (dump_start),
    .fin_o        (dump_fin),
    .reg_raddr_o  (reg_raddr),
    .reg_rdata_i  (reg_rdata),
    .dump_valid_o (dump_valid),
    .dump_idx_o   (dump_idx),
    .dump_data_o  (dump_data),
    .dump_ready_i (dump_ready)
  );

endmodule

// File: tb/tb_mips_run_ctrl.sv
// Directed bench for mips_run_ctrl (IMEM_DEPTH=16, TIMEOUT_CYC=50) with a
// behavioural core model: registered-read register file and a scripted halt.
module tb_mips_run_ctrl;

  logic        clk, rst, start, prog_valid, prog_last, cpu_halted, dump_ready;
  logic [31:0] prog_data, reg_rdata, imem_wdata, dump_data;
  logic        prog_ready, cpu_rst, imem_we, dump_valid, busy, done, timeout, overflow;
  logic [3:0]  imem_addr;
  logic [4:0]  reg_raddr, dump_idx;
  logic [5:0]  cycle_count;
`ifdef MIPS_RUN_CKSUM_EN
  logic [31:0] prog_cksum;
`endif

  mips_run_ctrl #(
    .DATA_W(32), .IMEM_DEPTH(16), .NUM_REGS(32),
    .DUMP_FIRST(0), .DUMP_COUNT(6), .TIMEOUT_CYC(50)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .prog_valid(prog_valid), .prog_data(prog_data), .prog_last(prog_last),
    .prog_ready(prog_ready), .cpu_rst(cpu_rst),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_halted(cpu_halted), .reg_raddr(reg_raddr), .reg_rdata(reg_rdata),
    .dump_valid(dump_valid), .dump_idx(dump_idx), .dump_data(dump_data),
    .dump_ready(dump_ready), .busy(busy), .done(done),
    .timeout(timeout), .overflow(overflow), .cycle_count(cycle_count)
`ifdef MIPS_RUN_CKSUM_EN
    ,
    .prog_cksum(prog_cksum)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [31:0] regs [32];
  logic [31:0] mem [16];
  logic [31:0] words [32];
  logic [31:0] exp_r [6];
  bit   [3:0]  pat;
  int n_chk, n_fail;
  int we_cnt, we_base, we_bad, dv_cyc, stall_cnt, stall_bad, done_cnt;
  logic [4:0]  dq_idx [$];
  logic [31:0] dq_data [$];
  bit          stall_prev;
  bit   [4:0]  p_idx;
  bit   [31:0] p_data;

  always @(posedge clk) reg_rdata <= regs[reg_raddr];

  // passive monitor: write sequencing, dump stability and handshaked words
  always @(negedge clk) begin
    if (rst) begin
      stall_prev <= 1'b0;
    end else begin
      if (imem_we) begin
        if (imem_addr != 4'(we_cnt - we_base) || imem_wdata != prog_data) we_bad <= we_bad + 1;
        mem[imem_addr] <= imem_wdata;
        we_cnt <= we_cnt + 1;
      end
      if (stall_prev && (!dump_valid || dump_idx != p_idx || dump_data != p_data))
        stall_bad <= stall_bad + 1;
      if (dump_valid) begin
        dv_cyc <= dv_cyc + 1;
        if (dump_ready) begin
          dq_idx.push_back(dump_idx);
          dq_data.push_back(dump_data);
        end else begin
          stall_cnt <= stall_cnt + 1;
        end
      end
      stall_prev <= dump_valid && !dump_ready;
      p_idx      <= dump_idx;
      p_data     <= dump_data;
      if (done) done_cnt <= done_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_dump(input int base);
    chk("dump_count", dq_idx.size() - base, 6);
    for (int i = 0; i < 6; i++) begin
      if (base + i < dq_idx.size()) begin
        chk("dump_idx", dq_idx[base + i], i);
        chk("dump_data", dq_data[base + i], exp_r[i]);
      end
    end
  endtask

  task automatic run_session(input int n, input bit use_last, input int halt_k,
                             input bit toggle, output int accepted, output bit dropped);
    bit stop, got_done;
    int runs;
    we_base = we_cnt; accepted = 0; dropped = 0; runs = 0; got_done = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int c = 0; c < n + 8; c++) begin
      prog_valid = 1'b1;
      prog_data  = words[accepted];
      prog_last  = use_last && (accepted == n - 1);
      @(negedge clk);
      stop = 1'b0;
      if (prog_ready) accepted++;
      else begin dropped = 1'b1; stop = 1'b1; end
      if (accepted == n) stop = 1'b1;
      @(posedge clk); #1;
      if (stop) break;
    end
    prog_valid = 1'b0; prog_last = 1'b0; prog_data = '0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (done) begin got_done = 1'b1; break; end
      if (!cpu_rst) runs++;
      @(posedge clk); #1;
      if (halt_k > 0 && runs == halt_k) cpu_halted = 1'b1;
      dump_ready = toggle ? pat[c % 4] : 1'b1;
    end
    chk("done_seen", got_done, 1);
    @(posedge clk); #1 cpu_halted = 1'b0; dump_ready = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int acc, db, dc, dv, sc;
    bit drop;
    rst = 1'b1; start = 1'b0; prog_valid = 1'b0; prog_last = 1'b0; prog_data = '0;
    cpu_halted = 1'b0; dump_ready = 1'b1; pat = 4'b1001;
    exp_r = '{32'd0, 32'd10, 32'd20, 32'd25, 32'd30, 32'd55};
    for (int i = 0; i < 32; i++) regs[i] = (i < 6) ? exp_r[i] : 32'hA5A5_0000 + i;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_cpu_rst", cpu_rst, 1);
    chk("rst_busy", busy, 0);
    chk("rst_ready", prog_ready, 0);
    chk("rst_flags", {done, timeout, overflow, dump_valid, imem_we}, 0);
    chk("rst_cc", cycle_count, 0);

    // ADDI/OR/ADD/HLT program, halt after 12 run cycles, dump_ready held high
    words[0] = 32'h2001000a; words[1] = 32'h20020014; words[2] = 32'h20030019;
    words[3] = 32'h00e73825; words[4] = 32'h00e73825; words[5] = 32'h00222020;
    words[6] = 32'h00e73825; words[7] = 32'h00832820; words[8] = 32'hfc000000;
    db = dq_idx.size(); dc = done_cnt; dv = dv_cyc;
    run_session(9, 1'b1, 12, 1'b0, acc, drop);
    chk("t1_accepted", acc, 9);
    chk("t1_we_count", we_cnt - we_base, 9);
    for (int i = 0; i < 9; i++) chk("t1_mem", mem[i], words[i]);
    chk("t1_cycles", cycle_count, 12);
    chk("t1_timeout", timeout, 0);
    chk("t1_overflow", overflow, 0);
    chk("t1_done_pulses", done_cnt - dc, 1);
    chk("t1_throughput", dv_cyc - dv, 6);
    check_dump(db);
    chk("t1_idle", {busy, cpu_rst}, 2'b01);

    // no halt: watchdog expires at 50
    words[0] = 32'h20010001; words[1] = 32'hfc000000;
    db = dq_idx.size(); dc = done_cnt;
    run_session(2, 1'b1, 0, 1'b0, acc, drop);
    chk("t2_cycles", cycle_count, 50);
    chk("t2_timeout", timeout, 1);
    chk("t2_overflow", overflow, 0);
    chk("t2_done_pulses", done_cnt - dc, 1);
    check_dump(db);

    // 18 words into 16-deep memory, no prog_last
    for (int i = 0; i < 18; i++) words[i] = 32'h1000_0000 + i;
    dc = done_cnt;
    run_session(18, 1'b0, 0, 1'b0, acc, drop);
    chk("t3_accepted", acc, 16);
    chk("t3_ready_dropped", drop, 1);
    chk("t3_we_count", we_cnt - we_base, 16);
    chk("t3_mem0", mem[0], 32'h1000_0000);
    chk("t3_mem15", mem[15], 32'h1000_000f);
    chk("t3_overflow", overflow, 1);
    chk("t3_done_pulses", done_cnt - dc, 1);

    // reset in the middle of RUN
    words[0] = 32'h20010001; words[1] = 32'hfc000000;
    we_base = we_cnt;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0; prog_valid = 1'b1; prog_data = words[0];
    @(posedge clk); #1 prog_data = words[1]; prog_last = 1'b1;
    @(posedge clk); #1 prog_valid = 1'b0; prog_last = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (!cpu_rst) break;
    end
    chk("t4_in_run", cpu_rst, 0);
    chk("t4_flags_cleared", {timeout, overflow}, 0);
    repeat (5) @(negedge clk);
    chk("t4_cycles_pre", cycle_count, 5);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("t4_cpu_rst", cpu_rst, 1);
    chk("t4_busy", busy, 0);
    chk("t4_cycles", cycle_count, 0);
    chk("t4_flags", {done, timeout, overflow, prog_ready, dump_valid}, 0);

    // clean run after reset, dump_ready toggling 1-0-0-1
    words[0] = 32'h2001000a; words[1] = 32'h20020014; words[2] = 32'h20030019;
    words[3] = 32'h00e73825; words[4] = 32'h00e73825; words[5] = 32'h00222020;
    words[6] = 32'h00e73825; words[7] = 32'h00832820; words[8] = 32'hfc000000;
    db = dq_idx.size(); dc = done_cnt; sc = stall_cnt;
    run_session(9, 1'b1, 7, 1'b1, acc, drop);
    chk("t5_cycles", cycle_count, 7);
    chk("t5_timeout", timeout, 0);
    chk("t5_done_pulses", done_cnt - dc, 1);
    chk("t5_stalls_seen", stall_cnt > sc, 1);
    check_dump(db);

`ifdef MIPS_RUN_CKSUM_EN
    words[0] = 32'h0000_0001; words[1] = 32'h0000_0002;
    run_session(2, 1'b1, 3, 1'b0, acc, drop);
    chk("ck_1_2", prog_cksum, 32'h0000_0000);
    words[0] = 32'h1234_5678;
    run_session(1, 1'b1, 3, 1'b0, acc, drop);
    chk("ck_single", prog_cksum, 32'h1234_5678);
    words[0] = 32'h8000_0000; words[1] = 32'h0000_0001;
    run_session(2, 1'b1, 3, 1'b0, acc, drop);
    chk("ck_wrap", prog_cksum, 32'h0000_0000);
`endif

    @(negedge clk);
    chk("imem_write_sequence", we_bad, 0);
    chk("dump_stability", stall_bad, 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_run_ctrl.md
Name: mips_run_ctrl

Overview:
Synthesizable program-load / run / register-dump controller for the MIPS32 pipelined core.
- Streams a program into instruction memory while holding the core in reset.
- Releases the core and counts cycles until HLT (halted) or a watchdog timeout.
- Reads out a parametrised window of the register file as a valid/ready stream.
- Replaces fixed-delay bench sequencing with handshaked, depth/width-generic control.

Parameters:
- DATA_W, 32, instruction and register word width
- IMEM_DEPTH, 1024, instruction memory words; address width is clog2(IMEM_DEPTH)
- NUM_REGS, 32, register file entries; address width is clog2(NUM_REGS)
- DUMP_FIRST, 0, first register index dumped
- DUMP_COUNT, 6, number of registers dumped; DUMP_FIRST+DUMP_COUNT <= NUM_REGS
- TIMEOUT_CYC, 1000, watchdog limit in run cycles; counter width is clog2(TIMEOUT_CYC+1)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  begin session; sampled in IDLE only
- prog_valid  in  1  program word valid
- prog_data  in  DATA_W  program word
- prog_last  in  1  final program word
- prog_ready  out  1  controller accepts word
- cpu_rst  out  1  core reset, active high
- imem_we  out  1  instruction memory write strobe
- imem_addr  out  clog2(IMEM_DEPTH)  write address
- imem_wdata  out  DATA_W  write data
- cpu_halted  in  1  core HALTED flag
- reg_raddr  out  clog2(NUM_REGS)  register read address
- reg_rdata  in  DATA_W  register data, valid one cycle after reg_raddr
- dump_valid  out  1  dump word valid
- dump_idx  out  clog2(NUM_REGS)  register index of dump word
- dump_data  out  DATA_W  register value
- dump_ready  in  1  consumer ready
- busy  out  1  not in IDLE
- done  out  1  one-cycle pulse at end of session
- timeout  out  1  sticky; watchdog expired in last session
- overflow  out  1  sticky; program exceeded IMEM_DEPTH
- cycle_count  out  counter width  run cycles of last session

Behaviour:
- Reset values: cpu_rst=1, all other outputs 0, state IDLE. Reset mid-session aborts immediately and re-enters IDLE with the same values.
- IDLE: prog_ready=0. If start=1: clear timeout, overflow and cycle_count; load address=0; go to LOAD.
- LOAD: cpu_rst=1, prog_ready=1.
  - Each prog_valid&prog_ready cycle drives imem_we=1, imem_addr=addr, imem_wdata=prog_data in that same cycle; addr increments.
  - Accepting a word with prog_last=1 moves to RUN on the next cycle.
  - Accepting a word at addr=IMEM_DEPTH-1 without prog_last sets overflow and moves to RUN. Later words are not accepted; no address wrap.
- RUN: cpu_rst=0 from the first RUN cycle. cycle_count increments every RUN cycle, saturating at TIMEOUT_CYC.
  - cpu_halted=1 goes to DUMP; that cycle is not counted.
  - cycle_count reaching TIMEOUT_CYC sets timeout and goes to DUMP.
  - If halt and timeout occur in the same cycle, halt wins and timeout stays 0.
- DUMP: cpu_rst stays 0 so the register file is held.
  - Each index i in DUMP_FIRST..DUMP_FIRST+DUMP_COUNT-1 gets one read cycle with reg_raddr=i.
  - The next cycle presents dump_valid=1, dump_idx=i, dump_data=reg_rdata captured into a holding register.
  - dump_valid/idx/data stay stable until dump_ready=1. The next read may overlap the handshake cycle.
  - Full throughput: one word per cycle when dump_ready is held high.
  - DUMP_COUNT=0 skips directly to DONE.
- DONE: one cycle. done=1, cpu_rst returns to 1, go to IDLE.
- start asserted outside IDLE is ignored.

Optional Feature:
MIPS_RUN_CKSUM_EN
- Defined: adds output prog_cksum[DATA_W-1:0].
  - Cleared on start.
  - Each accepted word updates it as prog_cksum = rotate_left(prog_cksum, 1) XOR word.
  - Holds its value after LOAD, for loader integrity checking.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Decomposition:
- Package mips_run_pkg holds:
  - state enum IDLE/LOAD/RUN/DUMP/DONE
  - clog2-derived width localparams
  - default TIMEOUT_CYC
  - the cksum rotate-xor function
- One sub-module, mips_run_dump_stream: read/holding-register/valid-ready skid for the DUMP phase.

Test Plan:
- Load the 9-word ADDI/OR/ADD/HLT program, model halts, dump_ready=1 -> six dump words R0..R5 = 0,10,20,25,30,55 with dump_idx 0..5, timeout=0, one done pulse.
- No halt, TIMEOUT_CYC=50 -> cycle_count=50, timeout=1, dump still emitted, done pulses.
- IMEM_DEPTH=4, stream 6 words without prog_last -> exactly 4 imem_we pulses at addresses 0..3, overflow=1, prog_ready=0 after the 4th word.
- dump_ready toggling 1-0-0-1 each cycle -> dump data and index never change while valid&&!ready; no word lost or duplicated.
- rst asserted during RUN -> next cycle cpu_rst=1, busy=0, all flags 0; a new start runs cleanly.
- With MIPS_RUN_CKSUM_EN, load words 1,2 -> prog_cksum = rotl(rotl(0)^1)^2 = 0x00000000; load 0x80000000,1 -> 0x00000000.
